// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, frame size and
// default timing constants for a 24 MHz system clock.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAITREL,
        ERR
    } ps2_state_e;

    localparam int PS2_FRAME_BITS        = 11;
    localparam int PS2_INHIBIT_CYCLES    = 2400;
    localparam int PS2_START_TIMEOUT     = 360000;
    localparam int PS2_XFER_TIMEOUT      = 48000;
    localparam int PS2_FILTER_LEN        = 8;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises one raw PS/2 line into the clk domain and rejects glitches
// shorter than FILTER_LEN samples; reports the accepted level and 1->0 strobe.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic          fall_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // A new level is accepted only after FILTER_LEN consecutive differing samples.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], line_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            fall_q  <= level_q & ~level_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibits the bus, requests to send,
// shifts the byte out on device clock falls and checks the device ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int START_TIMEOUT  = PS2_START_TIMEOUT,
    parameter int XFER_TIMEOUT   = PS2_XFER_TIMEOUT,
    parameter int FILTER_LEN     = PS2_FILTER_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int TMO_MAX_A = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
    localparam int TMO_MAX   = (TMO_MAX_A > INHIBIT_CYCLES) ? TMO_MAX_A : INHIBIT_CYCLES;
    localparam int TW        = $clog2(TMO_MAX + 1);

    ps2_state_e    state_q, state_d;
    logic [8:0]    shift_q, shift_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          data_oe_q, data_oe_d;
    logic          done_q, done_d;

    logic clk_lvl, clk_fall, data_lvl, data_fall_unused;
    logic xfer_expired;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk     (clk),
        .reset   (reset),
        .line_i  (ps2_clk_i),
        .level_o (clk_lvl),
        .fall_o  (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk     (clk),
        .reset   (reset),
        .line_i  (ps2_data_i),
        .level_o (data_lvl),
        .fall_o  (data_fall_unused)
    );

    assign xfer_expired = (tmo_q == TW'(XFER_TIMEOUT - 1));

    // SHIFT -> ACK -> WAITREL share one transfer window that starts at fall 1,
    // so the counter is not cleared on those two internal transitions.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bitcnt_d  = bitcnt_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        tmo_d     = (tmo_q == TW'(TMO_MAX)) ? tmo_q : tmo_q + 1'b1;

        case (state_q)
            IDLE: begin
                tmo_d     = '0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    shift_d  = {odd_parity(tx_data), tx_data};
                    bitcnt_d = '0;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (tmo_q == TW'(INHIBIT_CYCLES - 1)) begin
                    data_oe_d = 1'b1;
                    tmo_d     = '0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (clk_fall) begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b0, shift_q[8:1]};
                    bitcnt_d  = 4'd1;
                    tmo_d     = '0;
                    state_d   = SHIFT;
                end else if (tmo_q == TW'(START_TIMEOUT - 1)) begin
                    data_oe_d = 1'b0;
                    tmo_d     = '0;
                    state_d   = ERR;
                end
            end
            SHIFT: begin
                if (clk_fall) begin
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = ACK;
                    end else begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[8:1]};
                    end
                end else if (xfer_expired) begin
                    data_oe_d = 1'b0;
                    tmo_d     = '0;
                    state_d   = ERR;
                end
            end
            ACK: begin
                if (clk_fall) begin
                    bitcnt_d = 4'd11;
                    if (data_lvl) begin
                        tmo_d   = '0;
                        state_d = ERR;
                    end else begin
                        state_d = WAITREL;
                    end
                end else if (xfer_expired) begin
                    tmo_d   = '0;
                    state_d = ERR;
                end
            end
            WAITREL: begin
                if (clk_lvl && data_lvl) begin
                    done_d  = 1'b1;
                    tmo_d   = '0;
                    state_d = IDLE;
                end else if (xfer_expired) begin
                    tmo_d   = '0;
                    state_d = ERR;
                end
            end
            ERR: begin
                data_oe_d = 1'b0;
                tmo_d     = '0;
                state_d   = IDLE;
            end
            default: begin
                data_oe_d = 1'b0;
                tmo_d     = '0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bitcnt_q  <= '0;
            tmo_q     <= '0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bitcnt_q  <= bitcnt_d;
            tmo_q     <= tmo_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
        end
    end

    assign tx_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign tx_done     = done_q;
    assign tx_error    = (state_q == ERR);
    assign ps2_clk_oe  = (state_q == INHIBIT);
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host, and a scoreboard compares captured wire bits and outcome pulses.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH = 2400;
    localparam int STO = 3000;
    localparam int XTO = 4000;
    localparam int FL  = 8;
    localparam int H   = 40;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, busy, tx_done, tx_error;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk, dev_data, glitch;
    logic       ps2_clk_line, ps2_data_line;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         glitch;
        bit         inject;
        bit         exp_done;
        bit         exp_err;
    } vec_t;

    typedef struct {
        logic [9:0] bits;
        bit         done;
        bit         err;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[6];

    assign ps2_clk_line  = ~ps2_clk_oe & dev_clk & ~glitch;
    assign ps2_data_line = ~ps2_data_oe & dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (STO),
        .XFER_TIMEOUT   (XTO),
        .FILTER_LEN     (FL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .ps2_clk_i   (ps2_clk_line),
        .ps2_data_i  (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done)  done_cnt++;
        if (tx_error) err_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(posedge clk); #1;
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_data  = ~d;
    endtask

    // Device side: measures the inhibit, then clocks 11 falls, sampling data on each rise.
    task automatic dev_frame(input bit ack, input bit glt, input int stop_after,
                             output logic [9:0] bits, output bit started);
        int t;
        int inh;
        bits    = '0;
        started = 1'b0;
        t       = 0;
        @(negedge clk);
        while (!ps2_clk_oe && t < 100) begin @(negedge clk); t++; end
        if (!ps2_clk_oe) return;
        chk("inhibit_data_oe", ps2_data_oe, 1'b0);
        inh = 0;
        while (ps2_clk_oe && inh < INH + 100) begin @(negedge clk); inh++; end
        chk("inhibit_len", inh, INH);
        chk("start_bit", ps2_data_line, 1'b0);
        repeat (50) @(negedge clk);
        started = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            if (k == stop_after) begin
                repeat (20) @(negedge clk);
                return;
            end
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            if (k <= 10) bits[k-1] = ps2_data_line;
            if (k == 11) dev_data = 1'b1;
            if (k < 11) begin
                repeat (H/2) @(negedge clk);
                if (glt && k < 9) begin
                    glitch = 1'b1;
                    @(negedge clk);
                    glitch = 1'b0;
                end
                if (k == 10 && ack) dev_data = 1'b0;
                repeat (H/2) @(negedge clk);
            end
        end
    endtask

    task automatic xfer(input vec_t v);
        exp_t       e;
        logic [9:0] bits;
        bit         started;
        int         d0, e0, t;
        e.bits = {1'b1, ~^v.data, v.data};
        e.done = v.exp_done;
        e.err  = v.exp_err;
        exp_q.push_back(e);
        d0 = done_cnt;
        e0 = err_cnt;
        send(v.data);
        fork
            dev_frame(v.ack, v.glitch, 0, bits, started);
            begin
                if (v.inject) begin
                    repeat (INH + 300) @(negedge clk);
                    chk("busy_in_shift", busy, 1'b1);
                    tx_data  = 8'hAA;
                    tx_valid = 1'b1;
                    @(negedge clk);
                    tx_valid = 1'b0;
                end
            end
        join
        t = 0;
        while (done_cnt == d0 && err_cnt == e0 && t < 500) begin @(negedge clk); t++; end
        repeat (30) @(negedge clk);
        e = exp_q.pop_front();
        chk("device_clocked", started, 1'b1);
        chk($sformatf("wire_bits_%02h", v.data), bits, e.bits);
        chk($sformatf("done_pulses_%02h", v.data), done_cnt - d0, e.done);
        chk($sformatf("error_pulses_%02h", v.data), err_cnt - e0, e.err);
        chk("idle_after", tx_ready, 1'b1);
        chk("lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    endtask

    initial begin
        int         d0, e0, t, cnt;
        logic [9:0] bits;
        bit         started;

        vecs[0] = '{8'hED, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'hF4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        reset    = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        glitch   = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done_err", {tx_done, tx_error}, 2'b00);
        chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_ready", tx_ready, 1'b1);

        for (int i = 0; i < 6; i++) xfer(vecs[i]);

        // Device never clocks: error exactly STO cycles after the request begins.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h12);
        @(negedge clk);
        t = 0;
        while (ps2_clk_oe && t < INH + 100) begin @(negedge clk); t++; end
        chk("req_data_oe", ps2_data_oe, 1'b1);
        cnt = 0;
        while (!tx_error && cnt < STO + 100) begin @(negedge clk); cnt++; end
        chk("start_timeout_cycles", cnt, STO);
        chk("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        repeat (20) @(negedge clk);
        chk("timeout_err_pulses", err_cnt - e0, 1);
        chk("timeout_done_pulses", done_cnt - d0, 0);

        // Reset in the middle of a frame releases both lines without a clock edge.
        send(8'hC3);
        dev_frame(1'b1, 1'b0, 5, bits, started);
        chk("pre_reset_data_oe", ps2_data_oe, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        chk("async_rst_busy", busy, 1'b0);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        xfer('{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
